pipe_register: RTL
==================

PIPE_REGISTER -- requirements
Module: pipe_register

Interface
REQ-001 SHALL have parameter N, default 8, data width in bits (N >= 1).
REQ-002 SHALL have parameter STAGES, default 3, number of register stages (STAGES >= 1).
REQ-003 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port clear_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port flush  input  1  synchronous clear of all stages.
REQ-006 SHALL have port in_valid  input  1  upstream beat present.
REQ-007 SHALL have port in_ready  output  1  block accepts a beat this cycle.
REQ-008 SHALL have port in_data  input  N  upstream data.
REQ-009 SHALL have port out_valid  output  1  last stage holds a beat.
REQ-010 SHALL have port out_ready  input  1  downstream accepts a beat.
REQ-011 SHALL have port out_data  output  N  last-stage data.

Function
REQ-012 SHALL hold one valid bit and one N-bit data register per stage, stage 0 at input and stage STAGES-1 at output.
REQ-013 SHALL transfer a beat on a port only when valid and ready are both high in the same cycle.
REQ-014 SHALL compute per-stage ready as ready(i) = !valid(i) || ready(i+1), with ready(STAGES) = out_ready (bubble collapsing).
REQ-015 SHALL drive in_ready = ready(0) && !flush.
REQ-016 SHALL drive out_valid = valid(STAGES-1) and out_data = data(STAGES-1), with no combinational path from in_data.
REQ-017 SHALL advance stage i-1 into stage i on an edge only when valid(i-1) && ready(i), loading its data and setting valid(i).
REQ-018 SHALL clear valid(i) when stage i empties downstream and receives nothing from upstream.
REQ-019 SHALL leave a stage's data register unchanged whenever it does not load, whether it is holding or empty.
REQ-020 SHALL deliver a beat accepted into an empty pipe on out_valid exactly STAGES cycles after acceptance when out_ready stays high.
REQ-021 SHALL sustain one beat per cycle when out_ready stays high, including while all stages are full.
REQ-022 SHALL, when full with out_ready=1 and in_valid=1, drive in_ready=1 and accept and emit in the same cycle.
REQ-023 SHALL preserve beat order and SHALL never drop or duplicate a beat except through flush or reset.
REQ-024 SHALL keep out_data stable while out_valid=1 and out_ready=0.
REQ-025 SHALL, when flush=1, clear every valid bit on the next edge, ignore in_valid that cycle, and complete no output transfer on that edge.

Reset
REQ-026 SHALL, while clear_n=0, immediately force all valid bits to 0, making out_valid=0 independent of clk.
REQ-027 SHALL, while clear_n=0, force all data registers to 0 independent of clk.
REQ-028 SHALL show in_ready=1 during reset whenever flush=0.
REQ-029 SHALL resume normal operation on the first rising edge of clk after clear_n returns to 1.
REQ-030 SHALL discard every in-flight beat when clear_n is asserted mid-stream.

Configuration
REQ-031 SHALL, when macro PIPE_REGISTER_OCC_EN is defined, add output port occ, width $clog2(STAGES+1), equal to the registered count of valid stages.
REQ-032 SHALL update occ on every edge that changes any valid bit, clear it to 0 on flush or reset, and never let it exceed STAGES.
REQ-033 SHALL, when PIPE_REGISTER_OCC_EN is undefined, omit port occ and its counter, leaving all other behaviour identical.

Verification (N=8, STAGES=3)
REQ-034 Bench SHALL cover: clear_n=0 with flush=0 -> out_valid=0, out_data=0x00, in_ready=1, occ=0.
REQ-035 Bench SHALL cover: empty pipe, 0xA5 accepted at cycle 0, out_ready=1 -> out_valid=1 with 0xA5 during cycle 3 only.
REQ-036 Bench SHALL cover: 0x01..0x05 offered back-to-back with out_ready=0 -> 0x01..0x03 accepted, in_ready=0, occ=3, out_data=0x01 held; out_ready=1 -> 0x01..0x05 emitted in order, one per cycle.
REQ-037 Bench SHALL cover: full pipe, in_valid=1, out_ready=1 for 10 cycles -> in_ready=1 every cycle, 10 in and 10 out, occ=3 throughout.
REQ-038 Bench SHALL cover: occ=2, then flush=1 with in_valid=1 and in_data=0x77 -> next cycle out_valid=0, occ=0, and 0x77 never appears on out_data.
REQ-039 Bench SHALL cover: clear_n pulsed low between edges while occ=3 -> out_valid=0 at once; after release, new beat 0x3C emitted after 3 cycles with no stale data.

Source files
------------

// File: rtl/pipe_register.sv
// Elastic valid/ready register pipeline of STAGES stages with bubble collapsing.
// Define PIPE_REGISTER_OCC_EN to add the registered occupancy output occ.

module pipe_register_stage #(
    parameter int N = 8
) (
    input  logic         clk,
    input  logic         clear_n,
    input  logic         flush,
    input  logic         up_valid,
    input  logic [N-1:0] up_data,
    input  logic         ready,
    input  logic         down_ready,
    output logic         valid,
    output logic [N-1:0] data
);
    logic load;

    assign load = up_valid && ready && !flush;

    // Empty when the beat leaves downstream and nothing refills the slot.
    always_ff @(posedge clk or negedge clear_n) begin
        if (!clear_n)
            valid <= 1'b0;
        else if (flush)
            valid <= 1'b0;
        else if (load)
            valid <= 1'b1;
        else if (down_ready)
            valid <= 1'b0;
    end

    always_ff @(posedge clk or negedge clear_n) begin
        if (!clear_n)
            data <= '0;
        else if (load)
            data <= up_data;
    end
endmodule

module pipe_register #(
    parameter int N      = 8,
    parameter int STAGES = 3
) (
    input  logic                          clk,
    input  logic                          clear_n,
    input  logic                          flush,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [N-1:0]                  in_data,
    output logic                          out_valid,
    input  logic                          out_ready,
`ifdef PIPE_REGISTER_OCC_EN
    output logic [N-1:0]                  out_data,
    output logic [$clog2(STAGES+1)-1:0]   occ
`else
    output logic [N-1:0]                  out_data
`endif
);
    logic [STAGES-1:0]        valid;
    logic [STAGES-1:0][N-1:0] data;
    logic [STAGES:0]          ready;

    // Ready ripples from the output back toward the input.
    always_comb begin
        ready         = '0;
        ready[STAGES] = out_ready;
        for (int i = STAGES - 1; i >= 0; i--)
            ready[i] = !valid[i] || ready[i+1];
    end

    assign in_ready  = ready[0] && !flush;
    assign out_valid = valid[STAGES-1];
    assign out_data  = data[STAGES-1];

    for (genvar i = 0; i < STAGES; i++) begin : g_stage
        logic         up_valid;
        logic [N-1:0] up_data;

        if (i == 0) begin : g_head
            assign up_valid = in_valid;
            assign up_data  = in_data;
        end else begin : g_body
            assign up_valid = valid[i-1];
            assign up_data  = data[i-1];
        end

        pipe_register_stage #(.N(N)) u_stage (
            .clk        (clk),
            .clear_n    (clear_n),
            .flush      (flush),
            .up_valid   (up_valid),
            .up_data    (up_data),
            .ready      (ready[i]),
            .down_ready (ready[i+1]),
            .valid      (valid[i]),
            .data       (data[i])
        );
    end

`ifdef PIPE_REGISTER_OCC_EN
    localparam int OCC_W = $clog2(STAGES + 1);

    logic in_fire;
    logic out_fire;

    assign in_fire  = in_valid && in_ready;
    assign out_fire = out_valid && out_ready && !flush;

    always_ff @(posedge clk or negedge clear_n) begin
        if (!clear_n)
            occ <= '0;
        else if (flush)
            occ <= '0;
        else
            occ <= occ + OCC_W'(in_fire) - OCC_W'(out_fire);
    end
`endif
endmodule
